// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the burst RAM controller and its read buffer.
package ram_ctrl_pkg;

  localparam int AW_DEF    = 5;
  localparam int DW_DEF    = 32;
  localparam int RAM_DEPTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Two buffer slots are shared between words already buffered and reads still in flight.
  function automatic logic has_credit(input logic [1:0] occ, input logic inflight);
    return ({1'b0, occ} + {2'b00, inflight}) < 3'd2;
  endfunction

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry valid/ready FIFO capturing RAM read data; push has no ready because
// the controller only issues reads for which a slot is guaranteed.
module rd_skid_fifo #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  output logic          valid,
  input  logic          ready,
  output logic [DW-1:0] data,
  output logic [1:0]    count
);

  logic [DW-1:0] mem [2];
  logic          wptr;
  logic          rptr;
  logic [1:0]    cnt;
  logic          pop;

  assign valid = (cnt != 2'd0);
  assign pop   = valid && ready;
  assign data  = mem[rptr];
  assign count = cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wptr] <= push_data;
        wptr      <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/ram_ctrl.sv
// Burst initiator for the single-port RAM: streams write bursts in and read bursts out.
// Reads land one cycle after issue into a 2-entry buffer; issue stalls when no slot is free.
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wr,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          done,
  output logic          busy,
  output logic          cen,
  output logic          wen,
  output logic [AW-1:0] S_addr,
  output logic [DW-1:0] S_din,
  input  logic [DW-1:0] S_dout
);

  state_t        state;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] remaining;
  logic          inflight_q;
  logic [1:0]    occ;
  logic          wr_beat;
  logic          issue;

  assign wr_beat = (state == WRITE) && wr_valid;
  assign issue   = (state == READ) && has_credit(occ, inflight_q);

  // Gating with reset keeps the RAM quiet in the cycle an abort is requested.
  always_comb begin
    cen    = !reset && (wr_beat || issue);
    wen    = !reset && (state == WRITE);
    S_addr = ((state == WRITE) || (state == READ)) ? addr_q : '0;
    S_din  = (state == WRITE) ? wr_data : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      remaining  <= '0;
      inflight_q <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      cmd_ready  <= 1'b1;
      wr_ready   <= 1'b0;
    end else begin
      done       <= 1'b0;
      inflight_q <= issue;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_q    <= cmd_addr;
            remaining <= cmd_len;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            if (cmd_wr) begin
              state    <= WRITE;
              wr_ready <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end
        WRITE: begin
          if (wr_valid) begin
            addr_q <= addr_q + AW'(1);
            if (remaining == '0) begin
              state     <= IDLE;
              done      <= 1'b1;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
              wr_ready  <= 1'b0;
            end else begin
              remaining <= remaining - AW'(1);
            end
          end
        end
        READ: begin
          if (issue) begin
            addr_q <= addr_q + AW'(1);
            if (remaining == '0) begin
              state <= DRAIN;
            end else begin
              remaining <= remaining - AW'(1);
            end
          end
        end
        DRAIN: begin
          // The last read is captured at this edge, so completion is signalled next cycle.
          if (inflight_q) begin
            state     <= IDLE;
            done      <= 1'b1;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rd_skid_fifo #(
    .DW(DW)
  ) u_rd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight_q),
    .push_data (S_dout),
    .valid     (rd_valid),
    .ready     (rd_ready),
    .data      (rd_data),
    .count     (occ)
  );

endmodule

// File: tb/tb_ram_ctrl.sv
// Scoreboard bench for ram_ctrl with a behavioural 32x32 RAM attached.
module tb_ram_ctrl;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_wr;
  logic [AW-1:0] cmd_addr, cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready;
  logic [DW-1:0] rd_data;
  logic          done, busy, cen, wen;
  logic [AW-1:0] S_addr;
  logic [DW-1:0] S_din, S_dout;

  always #5 clk = ~clk;

  ram_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .busy(busy),
    .cen(cen), .wen(wen), .S_addr(S_addr), .S_din(S_din), .S_dout(S_dout)
  );

  logic [DW-1:0] mem [32];
  always @(posedge clk) begin
    if (cen && wen) mem[S_addr] <= S_din;
    else if (cen && !wen) S_dout <= mem[S_addr];
  end

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } acc_t;

  acc_t          exp_acc[$];
  logic [DW-1:0] exp_rd[$];
  logic [DW-1:0] wd[$];
  logic          wp[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_due = -1;
  int done_cnt = 0;
  int occ_m = 0;
  logic inf_m = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=missing/unexpected required=expected event", name);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Independent buffer model: a word lands one cycle after each read issue.
  always @(posedge clk) begin
    if (reset) begin
      occ_m <= 0;
      inf_m <= 1'b0;
    end else begin
      occ_m <= occ_m + int'(inf_m) - ((occ_m > 0 && rd_ready) ? 1 : 0);
      inf_m <= cen && !wen;
    end
  end

  always @(negedge clk) begin
    if (cen) begin
      if (exp_acc.size() == 0) begin
        fail_evt("unexpected_ram_access");
      end else begin
        acc_t e;
        e = exp_acc.pop_front();
        check("acc_wen", 64'(wen), 64'(e.wr));
        check("acc_addr", 64'(S_addr), 64'(e.addr));
        if (e.wr) check("acc_din", 64'(S_din), 64'(e.data));
        else check("read_credit", 64'((occ_m + int'(inf_m)) < 2), 64'd1);
        if (e.last) done_due = cyc + (e.wr ? 1 : 2);
      end
    end
    check("rd_valid", 64'(rd_valid), 64'(occ_m != 0));
    if (rd_valid && rd_ready) begin
      if (exp_rd.size() == 0) fail_evt("unexpected_rd_word");
      else check("rd_data", 64'(rd_data), 64'(exp_rd.pop_front()));
    end
    if (done) begin
      done_cnt++;
      check("done_cycle", 64'(cyc), 64'(done_due));
      done_due = -1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input logic [AW-1:0] len);
    int t = 0;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_len = len;
    @(negedge clk);
    while (!cmd_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!cmd_ready) fail_evt("cmd_accept_timeout");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int start);
    int t = 0;
    while (done_cnt == start && t < 200) begin
      t++;
      tick();
    end
    if (done_cnt == start) fail_evt("done_timeout");
    tick(); tick();
    check("done_once", 64'(done_cnt), 64'(start + 1));
  endtask

  task automatic drain_rd();
    int t = 0;
    while (exp_rd.size() != 0 && t < 100) begin
      t++;
      tick();
    end
    check("rd_words_left", 64'(exp_rd.size()), 64'd0);
  endtask

  // wd holds the words in order, wp the per-cycle wr_valid pattern.
  task automatic write_burst(input logic [AW-1:0] addr, input logic [AW-1:0] len);
    int start = done_cnt;
    int idx = 0;
    for (int i = 0; i <= int'(len); i++) begin
      acc_t e;
      e.wr = 1'b1; e.addr = addr + AW'(i); e.data = wd[i]; e.last = (i == int'(len));
      exp_acc.push_back(e);
    end
    send_cmd(1'b1, addr, len);
    for (int k = 0; k < wp.size(); k++) begin
      wr_valid = wp[k];
      wr_data  = wp[k] ? wd[idx] : 32'hDEAD_BEEF;
      @(negedge clk);
      check("cen_follows_wr_valid", 64'(cen), 64'(wp[k]));
      tick();
      if (wp[k]) idx++;
    end
    wr_valid = 1'b0;
    wait_done(start);
  endtask

  task automatic push_read(input logic [AW-1:0] addr, input logic [AW-1:0] len);
    for (int i = 0; i <= int'(len); i++) begin
      acc_t e;
      e.wr = 1'b0; e.addr = addr + AW'(i); e.data = '0; e.last = (i == int'(len));
      exp_acc.push_back(e);
      exp_rd.push_back(wd[i]);
    end
  endtask

  initial begin
    int start;
    int n;
    reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("rst_cen", 64'(cen), 64'd0);
    check("rst_wen", 64'(wen), 64'd0);
    check("rst_S_addr", 64'(S_addr), 64'd0);
    check("rst_S_din", 64'(S_din), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wr_ready", 64'(wr_ready), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    tick();
    reset = 1'b0;
    tick();

    // Back-to-back write burst at 0..3
    wd = '{32'h0A, 32'h0B, 32'h0C, 32'h0D};
    wp = '{1'b1, 1'b1, 1'b1, 1'b1};
    write_burst(5'd0, 5'd3);

    // Readback with first-word latency of two cycles after accept
    rd_ready = 1'b1;
    start = done_cnt;
    push_read(5'd0, 5'd3);
    send_cmd(1'b0, 5'd0, 5'd3);
    @(negedge clk);
    check("busy_in_read", 64'(busy), 64'd1);
    @(negedge clk);
    check("rd_latency_early", 64'(rd_valid), 64'd0);
    @(negedge clk);
    check("rd_latency_first", 64'(rd_valid), 64'd1);
    tick();
    wait_done(start);
    drain_rd();

    // Address wrap 30,31,0,1
    wd = '{32'd1, 32'd2, 32'd3, 32'd4};
    write_burst(5'd30, 5'd3);
    start = done_cnt;
    push_read(5'd30, 5'd3);
    send_cmd(1'b0, 5'd30, 5'd3);
    wait_done(start);
    drain_rd();

    // Write stall pattern into 4..7
    wd = '{32'h55, 32'h66, 32'h77, 32'h88};
    wp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    write_burst(5'd4, 5'd3);

    // Backpressure on an 8-word read of 0..7
    wd = '{32'd3, 32'd4, 32'h0C, 32'h0D, 32'h55, 32'h66, 32'h77, 32'h88};
    start = done_cnt;
    push_read(5'd0, 5'd7);
    send_cmd(1'b0, 5'd0, 5'd7);
    tick(); tick(); tick();
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rd_ready = 1'b1;
    wait_done(start);
    drain_rd();

    // Reset after the second issue of a long read
    rd_ready = 1'b0;
    start = done_cnt;
    for (int i = 0; i < 2; i++) begin
      acc_t e;
      e.wr = 1'b0; e.addr = 5'd4 + AW'(i); e.data = '0; e.last = 1'b0;
      exp_acc.push_back(e);
    end
    send_cmd(1'b0, 5'd4, 5'd7);
    n = 0;
    for (int t = 0; t < 20 && n < 2; t++) begin
      @(negedge clk);
      if (cen && !wen) n++;
    end
    check("reset_test_issues", 64'(n), 64'd2);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("abort_cen", 64'(cen), 64'd0);
    check("abort_rd_valid", 64'(rd_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 4; i++) tick();
    check("abort_no_done", 64'(done_cnt), 64'(start));
    rd_ready = 1'b1;
    wd = '{32'h55};
    start = done_cnt;
    push_read(5'd4, 5'd0);
    send_cmd(1'b0, 5'd4, 5'd0);
    wait_done(start);
    drain_rd();

    tick(); tick();
    check("acc_queue_empty", 64'(exp_acc.size()), 64'd0);
    check("done_pending", 64'(done_due), 64'(-1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
